// File: rtl/tinytout_pkg.sv
// Shared TinyTout definitions: loader FSM states and pin-interface constants.
// The stall address is also used by the top-level bus arbiter.
package tinytout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } loader_state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [7:0]  STALL_ADDR = 8'hFF;

endpackage

// File: rtl/serial_word_loader.sv
// Assembles four host bytes (LSB first) into a 32-bit word for the TinyTout core
// and presents it over a valid/ready handshake; partial words are dropped on timeout.
module serial_word_loader
    import tinytout_pkg::*;
#(
    parameter int unsigned NBYTES    = WORD_BYTES,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [7:0]  IDLE_ADDR = STALL_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            data_in,
    input  logic                  byte_valid,
    output logic [8*NBYTES-1:0]   word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [7:0]            address_out,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int unsigned     CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned     IDX_W       = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NBYTES - 1);
    localparam logic [CNT_W:0]  TIMEOUT_CMP = (CNT_W + 1)'(TIMEOUT);

    loader_state_t      state_reg, state_next;
    logic [IDX_W-1:0]   index_reg, index_next;
    logic [CNT_W-1:0]   idle_cnt_reg, idle_cnt_next;
    logic [CNT_W:0]     cnt_inc;
    logic [7:0]         addr_reg, addr_next;
    logic               word_valid_reg, word_valid_next;
    logic               busy_reg, busy_next;
    logic               timeout_err_reg, timeout_err_next;
    logic [NBYTES-1:0]  lane_we;
    logic               lane_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            index_reg       <= '0;
            idle_cnt_reg    <= '0;
            addr_reg        <= IDLE_ADDR;
            word_valid_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            index_reg       <= index_next;
            idle_cnt_reg    <= idle_cnt_next;
            addr_reg        <= addr_next;
            word_valid_reg  <= word_valid_next;
            busy_reg        <= busy_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        index_next       = index_reg;
        idle_cnt_next    = idle_cnt_reg;
        timeout_err_next = 1'b0;
        lane_we          = '0;
        lane_clr         = 1'b0;
        cnt_inc          = {1'b0, idle_cnt_reg} + (CNT_W + 1)'(1);

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next    = ST_COLLECT;
                    index_next    = '0;
                    idle_cnt_next = '0;
                    lane_clr      = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (byte_valid) begin
                    // An accepted byte always beats a coincident timeout.
                    lane_we[index_reg] = 1'b1;
                    idle_cnt_next      = '0;
                    if (index_reg == LAST_IDX) begin
                        state_next = ST_HOLD;
                    end else begin
                        index_next = index_reg + IDX_W'(1);
                    end
                end else begin
                    if (!cnt_inc[CNT_W]) begin
                        idle_cnt_next = cnt_inc[CNT_W-1:0];
                    end
                    if ((TIMEOUT != 0) && (cnt_inc == TIMEOUT_CMP)) begin
                        timeout_err_next = 1'b1;
                        state_next       = ST_IDLE;
                        index_next       = '0;
                        idle_cnt_next    = '0;
                        lane_clr         = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (word_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Status outputs are registered from the next state so they change with the edge.
        addr_next       = (state_next == ST_COLLECT) ? (8'h01 + 8'(index_next)) : IDLE_ADDR;
        busy_next       = (state_next != ST_IDLE);
        word_valid_next = (state_next == ST_HOLD);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg <= '0;
                end else if (lane_clr) begin
                    lane_reg <= '0;
                end else if (lane_we[gi]) begin
                    lane_reg <= data_in;
                end
            end
            assign word_out[8*gi +: 8] = lane_reg;
        end
    endgenerate

    assign address_out = addr_reg;
    assign word_valid  = word_valid_reg;
    assign busy        = busy_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_serial_word_loader.sv
// Bench for serial_word_loader: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the loader.
module tb_serial_word_loader;

    localparam int TO = 8;
    localparam int M_IDLE = 0, M_COLLECT = 1, M_HOLD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  data_in;
    logic        byte_valid;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  address_out;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // Model: which phase the transfer is in, the bytes gathered so far, idle run length.
    int          m_mode;
    logic [7:0]  m_q[$];
    int          m_silence;
    bit          m_terr;

    always #5 clk = ~clk;

    serial_word_loader #(
        .NBYTES    (4),
        .TIMEOUT   (TO),
        .IDLE_ADDR (8'hFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_in     (data_in),
        .byte_valid  (byte_valid),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .address_out (address_out),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_q();
        logic [31:0] w = '0;
        for (int i = 0; i < m_q.size(); i++) w[8*i +: 8] = m_q[i];
        return w;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_q.delete();
        m_silence = 0;
        m_terr = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic bv, input logic [7:0] d, input logic wr);
        m_terr = 1'b0;
        if (m_mode == M_IDLE) begin
            if (s) begin
                m_mode = M_COLLECT;
                m_q.delete();
                m_silence = 0;
            end
        end else if (m_mode == M_COLLECT) begin
            if (bv) begin
                m_q.push_back(d);
                m_silence = 0;
                if (m_q.size() == 4) m_mode = M_HOLD;
            end else begin
                m_silence++;
                if (m_silence == TO) begin
                    m_terr = 1'b1;
                    m_mode = M_IDLE;
                    m_q.delete();
                end
            end
        end else begin
            if (wr) m_mode = M_IDLE;
        end
    endtask

    task automatic compare();
        logic [7:0] exp_addr;
        exp_addr = (m_mode == M_COLLECT) ? (8'd1 + 8'(m_q.size())) : 8'hFF;
        chk("address_out", 32'(address_out), 32'(exp_addr));
        chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
        chk("word_valid", 32'(word_valid), 32'(m_mode == M_HOLD));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        if (m_mode == M_HOLD) chk("word_out", word_out, pack_q());
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, compare 1ns later.
    task automatic step(input logic s, input logic bv, input logic [7:0] d, input logic wr);
        @(negedge clk);
        start = s; byte_valid = bv; data_in = d; word_ready = wr;
        @(posedge clk);
        model_edge(s, bv, d, wr);
        #1 compare();
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0; byte_valid = 1'b0; word_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_address", 32'(address_out), 32'hFF);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_valid", 32'(word_valid), 32'h0);
        chk("rst_word", word_out, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_a [5];
        logic [7:0] b2 [4];
        logic [7:0] b3 [4];
        logic [7:0] b6 [4];
        int seen, k, rise, p;

        exp_a = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
        b2    = '{8'h04, 8'h00, 8'h08, 8'h8D};
        b3    = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        b6    = '{8'h78, 8'h56, 8'h34, 8'h12};

        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; data_in = 8'h00; word_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_address", 32'(address_out), 32'hFF);
        chk("reset_word", word_out, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_valid", 32'(word_valid), 32'h0);
        chk("reset_terr", 32'(timeout_err), 32'h0);
        rst = 1'b0;

        // Reset mid-COLLECT, then a fresh word must show no stale lanes.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'hA1, 0);
        step(0, 1, 8'hA2, 0);
        do_reset();
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h11, 0);
        step(0, 1, 8'h22, 0);
        step(0, 1, 8'h33, 0);
        step(0, 1, 8'h44, 0);
        chk("fresh_word", word_out, 32'h44332211);
        step(0, 0, 8'h00, 1);

        // Minimum-latency word with address stepping.
        step(1, 0, 8'h00, 0);
        chk("addr_seq0", 32'(address_out), 32'(exp_a[0]));
        for (int i = 0; i < 4; i++) begin
            step(0, 1, b2[i], 0);
            chk("addr_seq", 32'(address_out), 32'(exp_a[i+1]));
        end
        chk("min_lat_valid", 32'(word_valid), 32'h1);
        chk("min_lat_word", word_out, 32'h8D080004);
        step(0, 0, 8'h00, 1);

        // Gapped bytes, consumer stalls for 10 cycles.
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, b3[i], 0);
            if (i < 3) repeat (3) step(0, 0, 8'h00, 0);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 8'h5A, 0);
            chk("stall_word", word_out, 32'hDEADBEEF);
        end
        step(0, 0, 8'h00, 1);
        chk("stall_drop", 32'(word_valid), 32'h0);

        // Timeout after two bytes then silence.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h01, 0);
        step(0, 1, 8'h02, 0);
        seen = -1;
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 8'h00, 0);
            if (timeout_err) begin
                seen = i;
                break;
            end
        end
        chk("timeout_latency", 32'(seen), 32'd8);
        step(0, 0, 8'h00, 0);
        chk("timeout_single", 32'(timeout_err), 32'h0);
        chk("timeout_idle", 32'(busy), 32'h0);

        // A byte on the would-be timeout cycle wins.
        step(1, 0, 8'h00, 0);
        repeat (TO - 1) step(0, 0, 8'h00, 0);
        step(0, 1, 8'hC1, 0);
        chk("byte_beats_timeout", 32'(timeout_err), 32'h0);
        step(0, 1, 8'hC2, 0);
        step(0, 1, 8'hC3, 0);
        step(0, 1, 8'hC4, 0);
        chk("late_word", word_out, 32'hC4C3C2C1);
        step(0, 0, 8'h00, 1);

        // Start during COLLECT and bytes during HOLD are ignored.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h10, 0);
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h20, 0);
        step(0, 1, 8'h30, 0);
        step(0, 1, 8'h40, 0);
        step(1, 1, 8'hAA, 0);
        chk("hold_ignores_byte", word_out, 32'h40302010);
        step(0, 1, 8'hBB, 1);
        step(0, 0, 8'h00, 0);
        chk("no_queued_start", 32'(busy), 32'h0);

        // Back-to-back: handshake edge is edge 1, second word valid after edge 6.
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'hA0 + 8'(i), 0);
        step(0, 0, 8'h00, 1);
        k = 1; rise = -1;
        step(1, 0, 8'h00, 0);
        k++;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, b6[i], 0);
            k++;
            if (word_valid && rise < 0) rise = k;
        end
        chk("b2b_latency", 32'(rise), 32'd6);
        chk("b2b_word", word_out, 32'h12345678);
        step(0, 0, 8'h00, 1);

        // Random traffic with varying byte density and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            case (i / 500)
                0: p = 70;
                1: p = 30;
                2: p = 8;
                default: p = 95;
            endcase
            if ($urandom_range(299) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(7) == 0), ($urandom_range(99) < p),
                     8'($urandom_range(255)), $urandom_range(1) == 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
